fmac_accumulator: RTL



---
 rtl/fmac_pkg.sv | 25 ++
 rtl/fmac_lzc28.sv | 20 ++
 rtl/fmac_accumulator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fmac_pkg.sv
// rtl/fmac_pkg.sv - shared FSM encoding, fp32 field layout and constants for the fp32 accumulate stage
package fmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4
  } state_e;

  localparam int SIG_W        = 24;
  localparam int FRAC_W       = 23;
  localparam int EXP_W        = 8;
  localparam int SIGN_POS     = 31;
  localparam int EXP_LSB      = 23;
  localparam int FP32_BIAS    = 127;
  localparam int FP16_BIAS    = 15;
  localparam int PROD_EXP_OFS = 97;
  localparam int EXP_MAX      = 254;

  localparam logic [31:0] SAT_POS = 32'h7F7FFFFF;
  localparam logic [31:0] SAT_NEG = 32'hFF7FFFFF;

endpackage

// File: rtl/fmac_lzc28.sv
// rtl/fmac_lzc28.sv - combinational 28-bit leading-zero counter used by the normalize step
module fmac_lzc28 (
  input  logic [27:0] data_i,
  output logic [4:0]  count_o
);

  logic found;

  always_comb begin
    count_o = 5'd28;
    found   = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        count_o = 5'(27 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmac_accumulator.sv
// rtl/fmac_accumulator.sv - fp32 accumulate of fp16 products via align/add/normalize/round FSM
// Define FMAC_ROUND_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fmac_accumulator
  import fmac_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int GRS_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             prod_sign_i,
  input  logic [5:0]       prod_exp_i,
  input  logic [23:0]      prod_mant_i,
  input  logic             prod_zero_i,
  output logic [ACC_W-1:0] acc_out_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int EXT_W = SIG_W + GRS_W;
  localparam int SUM_W = EXT_W + 1;

  state_e state_q, state_d;

  logic                    op_sign_q, op_zero_q;
  logic [5:0]              op_exp_q;
  logic [21:0]             op_mant_q;
  logic [EXT_W-1:0]        a_sig_q, b_sig_q, norm_q;
  logic                    a_sign_q, b_sign_q, zero_q;
  logic signed [9:0]       exp_q;
  logic [SUM_W-1:0]        sum_q;
  logic [ACC_W-1:0]        acc_q;
  logic                    ovf_q, out_valid_q;
  logic                    accept;

  assign in_ready_o  = (state_q == ST_IDLE) && !clr_i;
  assign accept      = in_valid_i && in_ready_o;
  assign acc_out_o   = acc_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign ovf_o       = ovf_q;

  // The multiplier guarantees a product below 2^22, so the top two bits carry no information.
  logic unused_mant;
  assign unused_mant = ^prod_mant_i[23:22];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ALIGN;
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = ST_NORM;
      ST_NORM:  state_d = ST_ROUND;
      ST_ROUND: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (clr_i) state_d = ST_IDLE;
  end

  logic [7:0]         p_exp, acc_exp, big_exp, diff;
  logic [SIG_W-1:0]   p_sig, acc_sig, big_sig, small_sig;
  logic               big_sign, small_sign;
  logic [2*EXT_W-1:0] shift_ext;
  logic [EXT_W-1:0]   aligned;

  always_comb begin
    p_exp   = 8'(op_exp_q) + 8'(PROD_EXP_OFS) + {7'b0, op_mant_q[21]};
    p_sig   = op_mant_q[21] ? {op_mant_q[21:0], 2'b00} : {op_mant_q[20:0], 3'b000};
    acc_exp = acc_q[SIGN_POS-1:EXP_LSB];
    acc_sig = (acc_exp != '0) ? {1'b1, acc_q[FRAC_W-1:0]} : '0;
    if (p_exp >= acc_exp) begin
      big_exp    = p_exp;
      big_sig    = p_sig;
      big_sign   = op_sign_q;
      small_sig  = acc_sig;
      small_sign = acc_q[SIGN_POS];
      diff       = p_exp - acc_exp;
    end else begin
      big_exp    = acc_exp;
      big_sig    = acc_sig;
      big_sign   = acc_q[SIGN_POS];
      small_sig  = p_sig;
      small_sign = op_sign_q;
      diff       = acc_exp - p_exp;
    end
    // Bits shifted past the sticky position collapse into it.
    shift_ext = {small_sig, {(GRS_W + EXT_W){1'b0}}} >> diff;
    if (diff >= 8'(EXT_W)) begin
      aligned    = '0;
      aligned[0] = |small_sig;
    end else begin
      aligned    = shift_ext[2*EXT_W-1:EXT_W];
      aligned[0] = shift_ext[EXT_W] | (|shift_ext[EXT_W-1:0]);
    end
  end

  logic [SUM_W-1:0] ext_a, ext_b, sum_d;
  logic             sum_sign;

  always_comb begin
    ext_a = {1'b0, a_sig_q};
    ext_b = {1'b0, b_sig_q};
    if (a_sign_q == b_sign_q) begin
      sum_d    = ext_a + ext_b;
      sum_sign = a_sign_q;
    end else if (ext_a >= ext_b) begin
      sum_d    = ext_a - ext_b;
      sum_sign = a_sign_q;
    end else begin
      sum_d    = ext_b - ext_a;
      sum_sign = b_sign_q;
    end
  end

  logic [4:0]        lzc;
  logic [EXT_W-1:0]  norm_d;
  logic signed [9:0] norm_exp_d;

  // Trailing 1 caps the count at EXT_W when the sum is all zeros.
  fmac_lzc28 u_lzc (
    .data_i  ({sum_q[EXT_W-1:0], 1'b1}),
    .count_o (lzc)
  );

  always_comb begin
    if (sum_q[SUM_W-1]) begin
      norm_d     = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
      norm_exp_d = exp_q + 10'sd1;
    end else begin
      norm_d     = sum_q[EXT_W-1:0] << lzc;
      norm_exp_d = exp_q - $signed({5'b0, lzc});
    end
  end

  logic              round_up, sat;
  logic [SIG_W:0]    rsig;
  logic signed [9:0] rexp;
  logic [ACC_W-1:0]  result;

`ifdef FMAC_ROUND_RNE_EN
  assign round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
`else
  logic unused_grs;
  assign unused_grs = ^norm_q[GRS_W-1:0];
  assign round_up   = 1'b0;
`endif

  always_comb begin
    rsig = {1'b0, norm_q[EXT_W-1:GRS_W]} + {{SIG_W{1'b0}}, round_up};
    rexp = exp_q;
    if (rsig[SIG_W]) begin
      rsig = rsig >> 1;
      rexp = exp_q + 10'sd1;
    end
    sat = 1'b0;
    if (zero_q || rexp < 10'sd1) begin
      result = '0;
    end else if (rexp > $signed(10'(EXP_MAX))) begin
      sat    = 1'b1;
      result = a_sign_q ? SAT_NEG : SAT_POS;
    end else begin
      result = {a_sign_q, rexp[EXP_W-1:0], rsig[FRAC_W-1:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_sign_q   <= 1'b0;
      op_zero_q   <= 1'b0;
      op_exp_q    <= '0;
      op_mant_q   <= '0;
      a_sig_q     <= '0;
      b_sig_q     <= '0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      exp_q       <= '0;
      sum_q       <= '0;
      norm_q      <= '0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (clr_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (accept) begin
            op_sign_q <= prod_sign_i;
            op_zero_q <= prod_zero_i;
            op_exp_q  <= prod_exp_i;
            op_mant_q <= prod_mant_i[21:0];
          end
          ST_ALIGN: begin
            a_sig_q  <= {big_sig, {GRS_W{1'b0}}};
            b_sig_q  <= aligned;
            a_sign_q <= big_sign;
            b_sign_q <= small_sign;
            exp_q    <= $signed({2'b00, big_exp});
          end
          ST_ADD: begin
            sum_q    <= sum_d;
            a_sign_q <= sum_sign;
          end
          ST_NORM: begin
            norm_q <= norm_d;
            exp_q  <= norm_exp_d;
            zero_q <= (sum_q == '0);
          end
          ST_ROUND: begin
            out_valid_q <= 1'b1;
            if (!op_zero_q) begin
              acc_q <= result;
              if (sat) ovf_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
